// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception/eret flushes
// with a post-flush refill window, and counts stalled cycles. Optional watchdog: STALL_WDOG_EN.
module pipe_ctrl #(
    parameter int unsigned       N_REG      = 32,
    parameter logic [N_REG-1:0]  EXC_BASE   = N_REG'(32'h0000_0020),
    parameter int unsigned       REFILL_CYC = 2,
    parameter int unsigned       WDOG_LIMIT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stallreq_if,
    input  logic             i_stallreq_id,
    input  logic             i_stallreq_ex,
    input  logic             i_stallreq_mem,
    input  logic             i_excp_valid,
    input  logic             i_excp_eret,
    input  logic [N_REG-1:0] i_cp0_epc,
    output logic [5:0]       o_stall,
    output logic             o_flush,
    output logic [N_REG-1:0] o_new_pc,
    output logic             o_busy,
    output logic [31:0]      o_stall_cycles
`ifdef STALL_WDOG_EN
    ,
    output logic             o_wdog_trip
`endif
);

    localparam int unsigned REFILL_W = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;
    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_REFILL = 1'b1;

    if (REFILL_CYC < 1 || WDOG_LIMIT < 1) begin : g_param_check
        $error("pipe_ctrl: REFILL_CYC and WDOG_LIMIT must be at least 1");
    end

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [REFILL_W-1:0] refill_cnt;
    logic [REFILL_W-1:0] refill_nxt;
    logic [5:0]          stall_req;
    logic                wdog_hit;

    // Deepest stalling stage freezes itself and everything upstream of it.
    always_comb begin
        stall_req = 6'b000000;
        if (i_stallreq_mem)     stall_req = 6'b011111;
        else if (i_stallreq_ex) stall_req = 6'b001111;
        else if (i_stallreq_id) stall_req = 6'b000111;
        else if (i_stallreq_if) stall_req = 6'b000011;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_RUN;
            refill_cnt <= '0;
        end else begin
            state      <= state_nxt;
            refill_cnt <= refill_nxt;
        end
    end

    // Flush is Mealy on the exception so the redirect lands the same cycle.
    always_comb begin
        state_nxt  = state;
        refill_nxt = refill_cnt;
        o_flush    = 1'b0;
        o_new_pc   = '0;
        case (state)
            ST_RUN: begin
                if (i_excp_valid || wdog_hit) begin
                    o_flush    = 1'b1;
                    o_new_pc   = (i_excp_valid && i_excp_eret) ? i_cp0_epc : EXC_BASE;
                    state_nxt  = ST_REFILL;
                    refill_nxt = REFILL_W'(REFILL_CYC - 1);
                end
            end
            ST_REFILL: begin
                // Exceptions seen here are wrong-path remnants of the flushed window.
                if (refill_cnt == '0) state_nxt  = ST_RUN;
                else                  refill_nxt = refill_cnt - 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase
        o_stall = o_flush ? 6'b000000 : stall_req;
    end

    assign o_busy = (state != ST_RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                        o_stall_cycles <= '0;
        else if (o_stall[0] && (o_stall_cycles != 32'hFFFF_FFFF)) o_stall_cycles <= o_stall_cycles + 32'd1;
    end

`ifdef STALL_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // Trip on the cycle that would make the stall run WDOG_LIMIT long.
    assign wdog_hit    = (state == ST_RUN) && (stall_req != 6'b000000) &&
                         (wdog_cnt >= WDOG_W'(WDOG_LIMIT - 1));
    assign o_wdog_trip = wdog_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                              wdog_cnt <= '0;
        else if (o_flush || (o_stall == 6'b000000)) wdog_cnt <= '0;
        else if (wdog_cnt != WDOG_W'(WDOG_LIMIT))  wdog_cnt <= wdog_cnt + 1'b1;
    end
`else
    assign wdog_hit = 1'b0;
`endif

endmodule
